instr_loader: RTL
=================

Name: instr_loader

Overview:
- Program loader: the write-side master of the per-core instruction memory.
- Accepts a byte stream from the host/config side over a valid/ready handshake and assembles little-endian instruction words.
- Issues one write pulse per word on the memory's we/waddr/wdata port and holds the core in reset while loading.
- Verifies the load against a trailing XOR checksum byte.

Parameters:
- PC_WIDTH, `PC_WIDTH (8): instruction address width.
- INSTR_WIDTH, `INSTR_WIDTH (32): instruction width; must be a multiple of 8 and at least 16.
- DEPTH, 128: instruction memory depth; waddr wraps modulo DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- start_addr  in  PC_WIDTH  first word address.
- start_count  in  PC_WIDTH+1  number of words, 0..2^PC_WIDTH.
- abort  in  1  cancel load.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_ready  out  1  loader accepts a byte.
- we  out  1  memory write strobe.
- waddr  out  PC_WIDTH  memory write address.
- wdata  out  INSTR_WIDTH  memory write data.
- core_rst_n  out  1  held low while loading.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at load end.
- err  out  1  checksum mismatch; sticky until next accepted start.

Behaviour:
- Reset values: we=0, waddr=0, wdata=0, in_ready=0, busy=0, done=0, err=0, core_rst_n=0. All outputs are registered.
- Byte transfer occurs on an edge where in_valid and in_ready are both 1. in_valid may drop at any time; the loader never drops in_ready mid-stream except on state exit.
- States:
  - IDLE: in_ready=0, core_rst_n=1. On start: latch start_addr into waddr and start_count into words_left, clear err, checksum=0, byte_idx=0. Go to LOAD if count != 0, else CHECK.
  - LOAD: in_ready=1. Each accepted byte is XORed into the checksum and placed at bits [8*byte_idx +: 8] of the assembly register; byte_idx increments. On the byte with byte_idx = INSTR_WIDTH/8-1:
    - copy assembled word to wdata;
    - assert we for exactly the next cycle;
    - byte_idx := 0 and words_left decrements;
    - if words_left was 1, go to CHECK.
  - CHECK: in_ready=1. Accept one byte. err := (byte != checksum). Go to IDLE with done=1 for one cycle.
- Write latency: we is high in the cycle after the edge that accepted the word's last byte, with waddr = start_addr + word index (mod DEPTH).
- Address update: waddr advances on the edge ending the we cycle; DEPTH-1 wraps to 0. Bytes of the next word may be accepted during the we cycle.
- start_count > DEPTH is legal; addresses wrap and later words overwrite earlier ones.
- core_rst_n: 0 from the edge accepting start until the edge after done. It is 1 in IDLE once out of reset.
- start while busy: ignored.
- abort (any non-IDLE state): next state IDLE, in_ready=0. Any partial word is discarded with no we. done stays 0 and err is unchanged.
  - abort on the same edge as a word's last byte: abort wins, no we.
  - A we already high in the abort cycle completes normally.
- rst_n low at any time, including mid-load: immediate return to reset values on that edge.

Decomposition:
- Shared header: `PC_WIDTH and `INSTR_WIDTH defines, plus the state encoding localparams (IDLE, LOAD, CHECK).
- Sub-module instr_word_assembler handles byte_idx, the shift/placement register, running XOR and the word_complete strobe.
- instr_loader holds the FSM, counters, waddr/we/wdata registers and core_rst_n.

Test Plan:
- Basic load: start_addr=5, count=2; bytes 78 56 34 12 EF BE AD DE, checksum 2A -> we@5 wdata=0x12345678, we@6 wdata=0xDEADBEEF, done pulse, err=0, core_rst_n low throughout then 1.
- Bad checksum: same stream with checksum 00 -> both writes occur, done=1, err=1. err stays 1 until the next start, then clears.
- Wrap: start_addr=127, count=2, any bytes -> writes at waddr 127 then 0.
- Stalls: in_valid toggling every other cycle on the basic-load stream -> identical writes, exactly 2 we pulses, each 1 cycle.
- Abort: abort after 2 bytes of word 0 -> no we, busy=0 and in_ready=0 next cycle, no done. A subsequent basic load succeeds.
- Corners:
  - count=0 with checksum 00 -> no we, done=1, err=0.
  - rst_n asserted mid-LOAD -> all outputs at reset values on the next cycle.
  - start during LOAD -> ignored.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared widths and state encoding
// for the instruction memory loader.
`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package instr_loader_pkg;

  localparam int PC_W    = `PC_WIDTH;
  localparam int INSTR_W = `INSTR_WIDTH;
  localparam int DEPTH_D = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } ld_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream handshake plus the
// instruction memory write port.
interface instr_loader_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   we;
  logic [PC_WIDTH-1:0]    waddr;
  logic [INSTR_WIDTH-1:0] wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output we,
    output waddr,
    output wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  we,
    input  waddr,
    input  wdata
  );

endinterface

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte placement, byte index
// and running XOR checksum of the stream.
module instr_word_assembler #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_complete,
  output logic [7:0]             csum
);

  localparam int NB   = INSTR_WIDTH / 8;
  localparam int IDXW = $clog2(NB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  logic [INSTR_WIDTH-1:0] sh;
  logic [IDXW-1:0]        idx;

  assign word_complete = en && (idx == LAST_IDX);

  // Word as it stands once the current byte lands
  always_comb begin
    word = sh;
    word[8*idx +: 8] = byte_in;
  end

  // Byte index, partial word and checksum
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sh   <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (en) begin
      csum <= csum ^ byte_in;
      if (word_complete) begin
        sh  <= '0;
        idx <= '0;
      end else begin
        sh  <= word;
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a checksummed byte stream into
// instruction memory, core held in reset.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W,
  parameter int INSTR_WIDTH = INSTR_W,
  parameter int DEPTH       = DEPTH_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_addr,
  input  logic [PC_WIDTH:0]   start_count,
  input  logic                abort,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err,
  instr_loader_if.master      bus
);

  localparam logic [PC_WIDTH-1:0] LAST_A =
    PC_WIDTH'(DEPTH - 1);

  ld_state_t              state;
  logic [PC_WIDTH:0]      words_left;
  logic                   accept;
  logic                   asm_en;
  logic                   asm_clr;
  logic                   last_byte;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic [7:0]             csum;

  assign accept  = bus.in_valid && bus.in_ready;
  assign asm_en  = accept && !abort &&
                   (state == ST_LOAD);
  assign asm_clr = (state == ST_IDLE) || abort;

  instr_word_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (asm_clr),
    .en            (asm_en),
    .byte_in       (bus.in_data),
    .word          (asm_word),
    .word_complete (last_byte),
    .csum          (csum)
  );

  // Loader FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      words_left   <= '0;
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      done   <= 1'b0;
      if (bus.we)
        bus.waddr <= (bus.waddr == LAST_A) ?
                     '0 : bus.waddr + 1'b1;
      if (state != ST_IDLE && abort) begin
        state        <= ST_IDLE;
        bus.in_ready <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            core_rst_n <= 1'b1;
            if (start) begin
              bus.waddr    <= start_addr;
              words_left   <= start_count;
              err          <= 1'b0;
              core_rst_n   <= 1'b0;
              busy         <= 1'b1;
              bus.in_ready <= 1'b1;
              state <= (start_count != '0) ?
                       ST_LOAD : ST_CHECK;
            end
          end
          ST_LOAD: begin
            if (last_byte) begin
              bus.wdata  <= asm_word;
              bus.we     <= 1'b1;
              words_left <= words_left - 1'b1;
              if (words_left == 1)
                state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (accept) begin
              err          <= (bus.in_data != csum);
              done         <= 1'b1;
              busy         <= 1'b0;
              bus.in_ready <= 1'b0;
              state        <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
